alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Execute-stage sequencer sitting directly upstream of the ALU.
- Accepts one operation per valid/ready handshake from decode and launches it on the ALU with a one-cycle enable.
- Holds operands and opcode stable for the whole multi-cycle busy window (shift, divide), then captures the result and compare flags.
- Resolves the branch condition and presents result, tag and taken flag to writeback via valid/ready, with a saturating stall counter.

Parameters:
CNT_W, 16, width of saturating busy-stall counter O_stall_cnt
TAG_W, 5, width of destination tag (rd index) carried alongside the op

Ports:
I_clk  in  1  clock
I_reset  in  1  synchronous, active-high reset
I_valid  in  1  upstream op valid
O_ready  out  1  sequencer can accept op this cycle
I_op1  in  32  operand 1
I_op2  in  32  operand 2
I_aluop  in  5  ALU opcode (ALUOP_* encoding)
I_isbranch  in  1  op is a conditional branch
I_brfunc  in  3  branch funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
I_tag  in  TAG_W  destination tag
I_flush  in  1  kill in-flight op
O_alu_en  out  1  ALU enable pulse
O_alu_dataS1  out  32  ALU operand 1 (latched copy)
O_alu_dataS2  out  32  ALU operand 2 (latched copy)
O_alu_aluop  out  5  ALU opcode (latched copy)
I_alu_busy  in  1  ALU multi-cycle busy
I_alu_data  in  32  ALU result
I_alu_lt  in  1  ALU signed less-than flag
I_alu_ltu  in  1  ALU unsigned less-than flag
I_alu_eq  in  1  ALU equal flag
O_valid  out  1  result valid to writeback
I_ready  in  1  writeback accepts
O_data  out  32  captured result
O_tag  out  TAG_W  captured tag
O_taken  out  1  branch taken; 0 when the op is not a branch
O_stall_cnt  out  CNT_W  cycles spent in WAIT with I_alu_busy=1, saturating

Behaviour:
- Reset is synchronous, active-high on I_reset, clocked by I_clk.
  - After reset: state IDLE, O_valid=0, O_data=0, O_tag=0, O_taken=0, O_stall_cnt=0, kill=0.
  - After reset: latched operand/op registers = 0; O_alu_en=0.
  - The ALU shares the reset, so reset mid-operation needs no drain.
- States: IDLE, EXEC, WAIT, DONE.
- IDLE:
  - O_ready=1.
  - I_valid&&O_ready&&!I_flush latches op1, op2, aluop, isbranch, brfunc, tag -> EXEC.
- EXEC:
  - O_alu_en = !I_flush, high for exactly this cycle.
  - Flush -> IDLE. Otherwise -> WAIT.
- WAIT:
  - I_alu_busy=1: stay; O_stall_cnt += 1, saturating at all-ones.
  - I_alu_busy=0, kill=0: capture I_alu_data into O_data, latched tag into O_tag, computed taken into O_taken -> DONE.
  - I_alu_busy=0, kill=1: clear kill -> IDLE; outputs unchanged.
  - I_flush in WAIT sets kill. The ALU cannot be aborted, so the sequencer drains the busy window before returning to IDLE.
- DONE:
  - O_valid=1.
  - O_data/O_tag/O_taken held stable while I_ready=0.
  - O_ready = I_ready && !I_flush, which allows back-to-back issue.
  - I_ready=1 without a new op -> IDLE.
  - I_ready=1 with a new op accepted -> EXEC.
  - I_flush drops O_valid next cycle -> IDLE; no new op accepted that cycle.
- ALU-facing outputs are always driven from the latched registers. They never change between the EXEC cycle and the cycle after busy deasserts.
- Latency:
  - Single-cycle op: accept edge -> EXEC -> WAIT -> O_valid on the third cycle after accept.
  - Multi-cycle op: same, plus N cycles of I_alu_busy=1.
- Throughput: 1 op per 3 cycles for single-cycle ops.
- Taken function, using flags sampled when busy=0:
  - BEQ eq, BNE !eq.
  - BLT lt, BGE !lt.
  - BLTU ltu, BGEU !ltu.
  - 010/011: 0.
  - Forced 0 when isbranch=0.
- Simultaneous events:
  - I_reset beats everything.
  - I_flush beats accept and beats the output handshake.

Test Plan:
- ADD op1=5 op2=7, I_ready=1 -> O_alu_en one pulse; O_valid on cycle 3 after accept; O_data=12, O_taken=0, O_tag=latched value.
- SLL op1=1 op2=4, ALU holds busy 6 cycles -> O_alu_aluop/dataS1/dataS2 stable for all 6 cycles; O_data=16; O_stall_cnt=6.
- Branch BLT op1=0xFFFFFFFF op2=1 -> O_taken=1. Repeat with BLTU -> O_taken=0. BEQ op1=op2=0x80000000 -> O_taken=1.
- Backpressure: I_ready=0 for 5 cycles in DONE -> O_valid, O_data, O_tag stable and O_ready=0. Release with I_valid=1 -> new op accepted the same cycle; EXEC follows.
- I_flush in WAIT while busy=1 (divide) -> no O_valid; O_alu_en not reasserted until busy=0; IDLE next; a following ADD completes normally.
- I_reset asserted mid-WAIT -> next cycle all outputs at reset values, O_ready=1, O_stall_cnt=0.

Source files
------------

// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue: execute-stage sequencer that sits directly in front of the ALU.
//
// Takes one op per upstream handshake and fires it at the ALU with a
// single-cycle enable. Operands and opcode stay latched until the ALU's busy
// window ends. The sequencer then captures the result, resolves the branch
// condition and offers result/tag/taken to writeback.
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid && ready are both high. Valid never depends on ready. Upstream ready
// (O_ready) is high in IDLE. It is also high in DONE while writeback accepts
// (I_ready) and no flush is active, so a new op can issue back to back.
// I_flush beats both the upstream accept and the writeback handshake.
//
// Ports:
//   I_clk, I_reset        clock, synchronous active-high reset
//   I_valid/O_ready       upstream op handshake
//   I_op1, I_op2          operands
//   I_aluop               ALU opcode
//   I_isbranch, I_brfunc  conditional-branch marker and branch funct3
//   I_tag                 destination tag carried alongside the op
//   I_flush               kill the in-flight op
//   O_alu_en              one-cycle ALU launch pulse
//   O_alu_dataS1/S2       latched operands to the ALU
//   O_alu_aluop           latched opcode to the ALU
//   I_alu_busy            ALU multi-cycle busy
//   I_alu_data            ALU result
//   I_alu_lt/ltu/eq       ALU compare flags
//   O_valid/I_ready       writeback handshake
//   O_data, O_tag         captured result and tag
//   O_taken               branch taken (0 for non-branches)
//   O_stall_cnt           saturating count of busy cycles spent in WAIT
//   O_state               FSM state for debug/observation
// ---------------------------------------------------------------------------
module alu_issue #(
  parameter int CNT_W = 16,
  parameter int TAG_W = 5
) (
  input  logic             I_clk,
  input  logic             I_reset,
  input  logic             I_valid,
  output logic             O_ready,
  input  logic [31:0]      I_op1,
  input  logic [31:0]      I_op2,
  input  logic [4:0]       I_aluop,
  input  logic             I_isbranch,
  input  logic [2:0]       I_brfunc,
  input  logic [TAG_W-1:0] I_tag,
  input  logic             I_flush,
  output logic             O_alu_en,
  output logic [31:0]      O_alu_dataS1,
  output logic [31:0]      O_alu_dataS2,
  output logic [4:0]       O_alu_aluop,
  input  logic             I_alu_busy,
  input  logic [31:0]      I_alu_data,
  input  logic             I_alu_lt,
  input  logic             I_alu_ltu,
  input  logic             I_alu_eq,
  output logic             O_valid,
  input  logic             I_ready,
  output logic [31:0]      O_data,
  output logic [TAG_W-1:0] O_tag,
  output logic             O_taken,
  output logic [CNT_W-1:0] O_stall_cnt,
  output logic [1:0]       O_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state;
  logic               isbr_q;
  logic [2:0]         brfunc_q;
  logic [TAG_W-1:0]   tag_q;
  logic               kill;
  logic               accept;
  logic               taken_c;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  assign O_state = state;
  assign O_valid = (state == S_DONE);

  // The upstream may only be accepted in IDLE, or in DONE when the current
  // result is leaving the same cycle.
  always_comb begin
    O_ready = 1'b0;
    if (state == S_IDLE)
      O_ready = 1'b1;
    else if (state == S_DONE)
      O_ready = I_ready && !I_flush;
  end

  assign accept   = I_valid && O_ready && !I_flush;
  assign O_alu_en = (state == S_EXEC) && !I_flush;

  // Branch resolution from the flags presented when busy drops.
  always_comb begin
    taken_c = 1'b0;
    case (brfunc_q)
      3'b000:  taken_c = I_alu_eq;
      3'b001:  taken_c = !I_alu_eq;
      3'b100:  taken_c = I_alu_lt;
      3'b101:  taken_c = !I_alu_lt;
      3'b110:  taken_c = I_alu_ltu;
      3'b111:  taken_c = !I_alu_ltu;
      default: taken_c = 1'b0;
    endcase
    if (!isbr_q)
      taken_c = 1'b0;
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state        <= S_IDLE;
      O_alu_dataS1 <= '0;
      O_alu_dataS2 <= '0;
      O_alu_aluop  <= '0;
      isbr_q       <= 1'b0;
      brfunc_q     <= '0;
      tag_q        <= '0;
      kill         <= 1'b0;
      O_data       <= '0;
      O_tag        <= '0;
      O_taken      <= 1'b0;
      O_stall_cnt  <= '0;
    end else begin
      // The operand latch is shared by IDLE and DONE. Those are the only
      // states where accept can be high. This also keeps the ALU-facing
      // registers frozen from EXEC through the end of the busy window.
      if (accept) begin
        O_alu_dataS1 <= I_op1;
        O_alu_dataS2 <= I_op2;
        O_alu_aluop  <= I_aluop;
        isbr_q       <= I_isbranch;
        brfunc_q     <= I_brfunc;
        tag_q        <= I_tag;
      end

      case (state)
        S_IDLE: begin
          if (accept)
            state <= S_EXEC;
        end

        S_EXEC: begin
          if (I_flush)
            state <= S_IDLE;
          else
            state <= S_WAIT;
        end

        S_WAIT: begin
          if (I_alu_busy) begin
            // The ALU cannot be aborted, so a flush is remembered and the
            // busy window drains before the op is dropped.
            if (O_stall_cnt != CNT_MAX)
              O_stall_cnt <= O_stall_cnt + CNT_ONE;
            if (I_flush)
              kill <= 1'b1;
          end else if (kill || I_flush) begin
            kill  <= 1'b0;
            state <= S_IDLE;
          end else begin
            O_data  <= I_alu_data;
            O_tag   <= tag_q;
            O_taken <= taken_c;
            state   <= S_DONE;
          end
        end

        S_DONE: begin
          if (I_flush)
            state <= S_IDLE;
          else if (I_ready)
            state <= accept ? S_EXEC : S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue: directed bench for alu_issue. The bench plays both decode
// and the ALU. It presents hand-computed ALU results and flags, then checks
// the sequencer's outputs against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_alu_issue;

  localparam int CNT_W = 16;
  localparam int TAG_W = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Opcode values are opaque to the sequencer; these only label the steps.
  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_SLL = 5'd3;
  localparam logic [4:0] OP_DIV = 5'd12;

  logic             I_clk;
  logic             I_reset;
  logic             I_valid;
  logic             O_ready;
  logic [31:0]      I_op1;
  logic [31:0]      I_op2;
  logic [4:0]       I_aluop;
  logic             I_isbranch;
  logic [2:0]       I_brfunc;
  logic [TAG_W-1:0] I_tag;
  logic             I_flush;
  logic             O_alu_en;
  logic [31:0]      O_alu_dataS1;
  logic [31:0]      O_alu_dataS2;
  logic [4:0]       O_alu_aluop;
  logic             I_alu_busy;
  logic [31:0]      I_alu_data;
  logic             I_alu_lt;
  logic             I_alu_ltu;
  logic             I_alu_eq;
  logic             O_valid;
  logic             I_ready;
  logic [31:0]      O_data;
  logic [TAG_W-1:0] O_tag;
  logic             O_taken;
  logic [CNT_W-1:0] O_stall_cnt;
  logic [1:0]       O_state;

  int total = 0;
  int bad   = 0;

  alu_issue #(.CNT_W(CNT_W), .TAG_W(TAG_W)) dut (
    .I_clk(I_clk), .I_reset(I_reset), .I_valid(I_valid), .O_ready(O_ready),
    .I_op1(I_op1), .I_op2(I_op2), .I_aluop(I_aluop), .I_isbranch(I_isbranch),
    .I_brfunc(I_brfunc), .I_tag(I_tag), .I_flush(I_flush), .O_alu_en(O_alu_en),
    .O_alu_dataS1(O_alu_dataS1), .O_alu_dataS2(O_alu_dataS2),
    .O_alu_aluop(O_alu_aluop), .I_alu_busy(I_alu_busy), .I_alu_data(I_alu_data),
    .I_alu_lt(I_alu_lt), .I_alu_ltu(I_alu_ltu), .I_alu_eq(I_alu_eq),
    .O_valid(O_valid), .I_ready(I_ready), .O_data(O_data), .O_tag(O_tag),
    .O_taken(O_taken), .O_stall_cnt(O_stall_cnt), .O_state(O_state)
  );

  // ---- clock ----
  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  // ---- driver tasks ----
  // Inputs change just after the falling edge; outputs are sampled there too.
  task automatic tick();
    @(negedge I_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one op from IDLE and stops on the first DONE cycle. While the op
  // is in flight, garbage is driven on the decode side and on the ALU result
  // so that premature latching or capture shows up.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] op, input logic br, input logic [2:0] bf,
                        input logic [TAG_W-1:0] tg, input int nbusy,
                        input logic [31:0] res, input logic lt, input logic ltu,
                        input logic eq);
    I_valid = 1'b1; I_op1 = a; I_op2 = b; I_aluop = op;
    I_isbranch = br; I_brfunc = bf; I_tag = tg;
    #1 chk("acc_ready", O_ready, 1);
    tick();                                   // EXEC
    I_op1 = ~a; I_op2 = ~b; I_aluop = ~op; I_tag = ~tg; I_isbranch = ~br;
    #1;
    chk("exec_en", O_alu_en, 1);
    chk("exec_state", O_state, ST_EXEC);
    chk("exec_s1", O_alu_dataS1, a);
    chk("exec_s2", O_alu_dataS2, b);
    chk("exec_op", O_alu_aluop, op);
    I_alu_data = 32'hDEAD_BEEF;
    tick();                                   // WAIT
    for (int i = 0; i < nbusy; i++) begin
      I_alu_busy = 1'b1;
      #1;
      chk("busy_en", O_alu_en, 0);
      chk("busy_valid", O_valid, 0);
      chk("busy_s1", O_alu_dataS1, a);
      chk("busy_s2", O_alu_dataS2, b);
      chk("busy_op", O_alu_aluop, op);
      tick();
    end
    I_alu_busy = 1'b0; I_alu_data = res;
    I_alu_lt = lt; I_alu_ltu = ltu; I_alu_eq = eq;
    #1;
    chk("wait_valid", O_valid, 0);
    chk("wait_state", O_state, ST_WAIT);
    tick();                                   // DONE
    I_valid = 1'b0;
    I_alu_data = 32'h0BAD_0BAD;
    #1;
    chk("done_valid", O_valid, 1);
  endtask

  // ---- directed sequence ----
  initial begin
    I_reset = 1'b1; I_valid = 1'b0; I_op1 = '0; I_op2 = '0; I_aluop = '0;
    I_isbranch = 1'b0; I_brfunc = '0; I_tag = '0; I_flush = 1'b0;
    I_alu_busy = 1'b0; I_alu_data = '0; I_alu_lt = 1'b0; I_alu_ltu = 1'b0;
    I_alu_eq = 1'b0; I_ready = 1'b1;
    tick(); tick();
    I_reset = 1'b0;
    #1;
    chk("rst_valid", O_valid, 0);
    chk("rst_ready", O_ready, 1);
    chk("rst_data", O_data, 0);
    chk("rst_tag", O_tag, 0);
    chk("rst_taken", O_taken, 0);
    chk("rst_stall", O_stall_cnt, 0);
    chk("rst_en", O_alu_en, 0);
    chk("rst_s1", O_alu_dataS1, 0);
    chk("rst_state", O_state, ST_IDLE);

    // ADD 5+7: result on the third cycle after accept.
    run_op(32'd5, 32'd7, OP_ADD, 1'b0, 3'b000, 5'd3, 0, 32'd12, 1'b1, 1'b1, 1'b0);
    chk("add_data", O_data, 32'd12);
    chk("add_tag", O_tag, 5'd3);
    chk("add_taken", O_taken, 0);
    tick();
    chk("add_idle", O_state, ST_IDLE);
    chk("add_valid_drop", O_valid, 0);

    // Non-branch with eq=1 and a BEQ funct3 must not report taken.
    run_op(32'd9, 32'd9, OP_ADD, 1'b0, 3'b000, 5'd4, 0, 32'd18, 1'b0, 1'b0, 1'b1);
    chk("nobr_data", O_data, 32'd18);
    chk("nobr_taken", O_taken, 0);
    tick();

    // SLL 1<<4 with 6 busy cycles.
    run_op(32'd1, 32'd4, OP_SLL, 1'b0, 3'b000, 5'd5, 6, 32'd16, 1'b0, 1'b0, 1'b0);
    chk("sll_data", O_data, 32'd16);
    chk("sll_tag", O_tag, 5'd5);
    chk("sll_stall", O_stall_cnt, 16'd6);
    tick();

    // Branches: -1 vs 1 -> lt=1, ltu=0, eq=0.
    run_op(32'hFFFF_FFFF, 32'd1, OP_SUB, 1'b1, 3'b100, 5'd6, 0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    chk("blt_taken", O_taken, 1);
    chk("blt_tag", O_tag, 5'd6);
    tick();
    run_op(32'hFFFF_FFFF, 32'd1, OP_SUB, 1'b1, 3'b110, 5'd6, 0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    chk("bltu_taken", O_taken, 0);
    tick();
    run_op(32'hFFFF_FFFF, 32'd1, OP_SUB, 1'b1, 3'b111, 5'd6, 0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    chk("bgeu_taken", O_taken, 1);
    tick();
    run_op(32'hFFFF_FFFF, 32'd1, OP_SUB, 1'b1, 3'b101, 5'd6, 0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    chk("bge_taken", O_taken, 0);
    tick();
    // Equal operands: eq=1, lt=0, ltu=0.
    run_op(32'h8000_0000, 32'h8000_0000, OP_SUB, 1'b1, 3'b000, 5'd7, 0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("beq_taken", O_taken, 1);
    tick();
    run_op(32'h8000_0000, 32'h8000_0000, OP_SUB, 1'b1, 3'b001, 5'd7, 0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("bne_taken", O_taken, 0);
    tick();
    // Unused funct3 010 with every flag high is never taken.
    run_op(32'd3, 32'd3, OP_SUB, 1'b1, 3'b010, 5'd7, 0, 32'd0, 1'b1, 1'b1, 1'b1);
    chk("f010_taken", O_taken, 0);
    tick();

    // Backpressure for 5 cycles, then release with a new op the same cycle.
    run_op(32'd20, 32'd22, OP_ADD, 1'b0, 3'b000, 5'd7, 0, 32'd42, 1'b0, 1'b0, 1'b0);
    I_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", O_valid, 1);
      chk("bp_data", O_data, 32'd42);
      chk("bp_tag", O_tag, 5'd7);
      chk("bp_ready", O_ready, 0);
      tick();
    end
    I_ready = 1'b1; I_valid = 1'b1;
    I_op1 = 32'd1; I_op2 = 32'd2; I_aluop = OP_ADD; I_isbranch = 1'b0; I_tag = 5'd8;
    #1 chk("bp_release_ready", O_ready, 1);
    tick();
    I_valid = 1'b0;
    #1;
    chk("b2b_state", O_state, ST_EXEC);
    chk("b2b_en", O_alu_en, 1);
    chk("b2b_s1", O_alu_dataS1, 32'd1);
    I_alu_data = 32'd3;
    tick(); tick();
    chk("b2b_valid", O_valid, 1);
    chk("b2b_data", O_data, 32'd3);
    chk("b2b_tag", O_tag, 5'd8);
    tick();

    // Flush during a divide's busy window: drains, no result, back to IDLE.
    I_valid = 1'b1; I_op1 = 32'd100; I_op2 = 32'd7; I_aluop = OP_DIV; I_tag = 5'd9;
    tick();
    I_valid = 1'b0;
    #1 chk("div_en", O_alu_en, 1);
    tick();
    I_alu_busy = 1'b1;
    tick();
    I_flush = 1'b1;
    tick();
    I_flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("kill_en", O_alu_en, 0);
      chk("kill_valid", O_valid, 0);
      chk("kill_state", O_state, ST_WAIT);
      tick();
    end
    I_alu_busy = 1'b0; I_alu_data = 32'd14;
    tick();
    chk("kill_idle", O_state, ST_IDLE);
    chk("kill_no_valid", O_valid, 0);
    chk("kill_data_held", O_data, 32'd3);
    chk("kill_tag_held", O_tag, 5'd8);
    chk("kill_stall", O_stall_cnt, 16'd11);
    run_op(32'd2, 32'd3, OP_ADD, 1'b0, 3'b000, 5'd10, 0, 32'd5, 1'b0, 1'b0, 1'b0);
    chk("post_kill_data", O_data, 32'd5);
    chk("post_kill_tag", O_tag, 5'd10);
    tick();

    // Flush in DONE beats both handshakes.
    run_op(32'd4, 32'd4, OP_ADD, 1'b0, 3'b000, 5'd11, 0, 32'd8, 1'b0, 1'b0, 1'b1);
    I_flush = 1'b1; I_valid = 1'b1; I_op1 = 32'h55; I_tag = 5'd12;
    #1 chk("dflush_ready", O_ready, 0);
    tick();
    I_flush = 1'b0; I_valid = 1'b0;
    #1;
    chk("dflush_state", O_state, ST_IDLE);
    chk("dflush_valid", O_valid, 0);
    chk("dflush_en", O_alu_en, 0);
    chk("dflush_s1", O_alu_dataS1, 32'd4);

    // Reset in the middle of WAIT.
    I_valid = 1'b1; I_op1 = 32'd50; I_op2 = 32'd5; I_aluop = OP_DIV; I_tag = 5'd13;
    tick();
    I_valid = 1'b0;
    tick();
    I_alu_busy = 1'b1;
    tick(); tick();
    chk("pre_rst_stall", O_stall_cnt, 16'd13);
    I_reset = 1'b1;
    tick();
    I_reset = 1'b0; I_alu_busy = 1'b0;
    #1;
    chk("mrst_state", O_state, ST_IDLE);
    chk("mrst_valid", O_valid, 0);
    chk("mrst_ready", O_ready, 1);
    chk("mrst_stall", O_stall_cnt, 0);
    chk("mrst_data", O_data, 0);
    chk("mrst_tag", O_tag, 0);
    chk("mrst_s1", O_alu_dataS1, 0);
    chk("mrst_s2", O_alu_dataS2, 0);
    chk("mrst_op", O_alu_aluop, 0);
    chk("mrst_en", O_alu_en, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
